// File: rtl/fdivsqrt_srt2_iter.sv
// Radix-2 SRT divide iteration engine: carry-save residual, on-the-fly quotient
// conversion, DIVCOPIES digit selectors chained per clock.
module fdivsqrt_srt2_step #(
  parameter int W = 27,
  parameter int K = 26
) (
  input  logic [W-2:0] ws,
  input  logic [W-2:0] wc,
  input  logic [W-1:0] d,
  input  logic [K-2:0] qr,
  input  logic [K-2:0] qmr,
  output logic [W-1:0] ws_n,
  output logic [W-1:0] wc_n,
  output logic [K-1:0] qr_n,
  output logic [K-1:0] qmr_n
);
  logic [W-1:0] ws2, wc2, add;
  logic [W-2:0] maj;
  logic [3:0]   t;
  logic         zero, pos, neg;

  // Incoming MSB is dropped: 2W always fits the residual format.
  assign ws2  = {ws, 1'b0};
  assign wc2  = {wc, 1'b0};
  assign t    = ws2[W-1:W-4] + wc2[W-1:W-4];
  assign zero = (t == 4'hf) | ((t == 4'h0) & ~ws2[W-5] & ~wc2[W-5]);
  assign pos  = ~zero & ~t[3];
  assign neg  = ~zero & t[3];

  assign add  = pos ? ~d : (neg ? d : '0);
  assign maj  = (ws2[W-2:0] & wc2[W-2:0]) | (ws2[W-2:0] & add[W-2:0]) |
                (wc2[W-2:0] & add[W-2:0]);
  assign ws_n = ws2 ^ wc2 ^ add;
  assign wc_n = {maj, pos};

  always_comb begin
    qr_n  = {qr, 1'b0};
    qmr_n = {qmr, 1'b1};
    if (pos) begin
      qr_n  = {qr, 1'b1};
      qmr_n = {qr, 1'b0};
    end else if (neg) begin
      qr_n  = {qmr, 1'b1};
      qmr_n = {qmr, 1'b0};
    end
  end
endmodule

module fdivsqrt_srt2_iter #(
  parameter int N         = 24,
  parameter int DIVCOPIES = 1,
  parameter int ITER      = (N + 2 + DIVCOPIES - 1) / DIVCOPIES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] X,
  input  logic [N-1:0] D,
  output logic         busy,
  output logic         done,
  output logic [N+1:0] Q,
  output logic         sticky
);
  localparam int W  = N + 3;
  localparam int K  = ITER * DIVCOPIES;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;

  state_t                      state;
  logic [W-1:0]                ws, wc, dreg, wsum;
  logic [K-1:0]                qr, qmr, qsel;
  logic [CW-1:0]               cnt;
  logic [DIVCOPIES:0][W-1:0]   ws_c, wc_c;
  logic [DIVCOPIES:0][K-1:0]   qr_c, qmr_c;

  assign ws_c[0]  = ws;
  assign wc_c[0]  = wc;
  assign qr_c[0]  = qr;
  assign qmr_c[0] = qmr;

  for (genvar i = 0; i < DIVCOPIES; i++) begin : g_step
    fdivsqrt_srt2_step #(.W(W), .K(K)) u_step (
      .ws   (ws_c[i][W-2:0]),
      .wc   (wc_c[i][W-2:0]),
      .d    (dreg),
      .qr   (qr_c[i][K-2:0]),
      .qmr  (qmr_c[i][K-2:0]),
      .ws_n (ws_c[i+1]),
      .wc_n (wc_c[i+1]),
      .qr_n (qr_c[i+1]),
      .qmr_n(qmr_c[i+1])
    );
  end

  // A negative final residual means the last +1 overshot: take Q-1.
  assign wsum = ws_c[0] + wc_c[0];
  assign qsel = wsum[W-1] ? qmr_c[0] : qr_c[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      Q      <= '0;
      sticky <= 1'b0;
      ws     <= '0;
      wc     <= '0;
      qr     <= '0;
      qmr    <= '0;
      dreg   <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ITERATE: begin
            ws  <= ws_c[DIVCOPIES];
            wc  <= wc_c[DIVCOPIES];
            qr  <= qr_c[DIVCOPIES];
            qmr <= qmr_c[DIVCOPIES];
            if (cnt == '0) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          DONE: begin
            done   <= 1'b1;
            Q      <= qsel[K-1:K-N-2];
            sticky <= |wsum;
            state  <= IDLE;
          end
          default: ;
        endcase
        // X/2 in Q3.N is X's integer pattern zero-extended; D gains one LSB.
        if (start && (state != ITERATE)) begin
          ws    <= {3'b000, X};
          wc    <= '0;
          qr    <= '0;
          qmr   <= '0;
          dreg  <= {2'b00, D, 1'b0};
          cnt   <= CW'(ITER - 1);
          state <= ITERATE;
          busy  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fdivsqrt_srt2_iter.sv
// Directed bench for fdivsqrt_srt2_iter: three instances (1, 2 and 3 digits per
// clock) share stimulus; quotient, sticky, latency and handshake are checked.
module tb_fdivsqrt_srt2_iter;
  localparam int N = 24;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] d;
    logic [N+1:0] q;
    logic         s;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N-1:0]     X = '0;
  logic [N-1:0]     D = '0;
  logic [2:0]       busy, done, sticky;
  logic [2:0][N+1:0] Q;

  int pass_cnt = 0;
  int total    = 0;
  int lat[3], nbusy[3], ndone[3];
  logic [N+1:0] rq[3];
  logic         rs[3];
  int exp_iter[3] = '{26, 13, 9};
  vec_t vt[10];

  always #5 clk = ~clk;

  fdivsqrt_srt2_iter #(.N(N), .DIVCOPIES(1)) u_c1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .X(X), .D(D),
    .busy(busy[0]), .done(done[0]), .Q(Q[0]), .sticky(sticky[0]));
  fdivsqrt_srt2_iter #(.N(N), .DIVCOPIES(2)) u_c2 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .X(X), .D(D),
    .busy(busy[1]), .done(done[1]), .Q(Q[1]), .sticky(sticky[1]));
  fdivsqrt_srt2_iter #(.N(N), .DIVCOPIES(3)) u_c3 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .X(X), .D(D),
    .busy(busy[2]), .done(done[2]), .Q(Q[2]), .sticky(sticky[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Launch one op; optional extra start pulses (p1/p2) and abort (ab) are
  // driven after the sample with that index. Sample k follows edge k.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] d,
                        input int p1, input int p2, input int ab);
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; nbusy[i] = 0; ndone[i] = 0; rq[i] = '0; rs[i] = 1'b0;
    end
    X = x; D = d; start = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      X = 24'hc00000; D = 24'h800000;
      for (int i = 0; i < 3; i++) begin
        if (busy[i]) nbusy[i]++;
        if (done[i]) begin
          ndone[i]++;
          if (lat[i] == 0) begin
            lat[i] = k; rq[i] = Q[i]; rs[i] = sticky[i];
          end
        end
      end
      start = (k == p1) || (k == p2);
      abort = (k == ab);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [N+1:0] eq, input logic es);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s c%0d q", tag, i + 1), 64'(rq[i]), 64'(eq));
      chk($sformatf("%s c%0d sticky", tag, i + 1), 64'(rs[i]), 64'(es));
      chk($sformatf("%s c%0d latency", tag, i + 1), 64'(lat[i]), 64'(exp_iter[i] + 1));
      chk($sformatf("%s c%0d busy cycles", tag, i + 1), 64'(nbusy[i]), 64'(exp_iter[i]));
      chk($sformatf("%s c%0d done pulses", tag, i + 1), 64'(ndone[i]), 64'd1);
    end
  endtask

  initial begin
    vt[0] = '{24'h800000, 24'h800000, 26'h2000000, 1'b0};
    vt[1] = '{24'hc00000, 24'h800000, 26'h3000000, 1'b0};
    vt[2] = '{24'h800000, 24'hc00000, 26'h1555555, 1'b1};
    vt[3] = '{24'he00000, 24'ha00000, 26'h2cccccc, 1'b1};
    vt[4] = '{24'h800000, 24'ha00000, 26'h1999999, 1'b1};
    vt[5] = '{24'hf00000, 24'ha00000, 26'h3000000, 1'b0};
    vt[6] = '{24'hffffff, 24'h800000, 26'h3fffffc, 1'b0};
    vt[7] = '{24'h800001, 24'hc00000, 26'h1555558, 1'b0};
    vt[8] = '{24'h800000, 24'he00000, 26'h1249249, 1'b1};
    vt[9] = '{24'hc00000, 24'hc00000, 26'h2000000, 1'b0};

    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset c%0d busy", i + 1), 64'(busy[i]), 64'd0);
      chk($sformatf("reset c%0d done", i + 1), 64'(done[i]), 64'd0);
      chk($sformatf("reset c%0d q", i + 1), 64'(Q[i]), 64'd0);
      chk($sformatf("reset c%0d sticky", i + 1), 64'(sticky[i]), 64'd0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      run_op(vt[v].x, vt[v].d, -1, -1, -1);
      check_op($sformatf("vec%0d", v), vt[v].q, vt[v].s);
    end

    // Starts while busy are ignored; result is from the first operands.
    run_op(24'h800000, 24'hc00000, 3, 7, -1);
    check_op("restart_ignored", 26'h1555555, 1'b1);

    // Abort mid-iteration: no done, previous result held.
    run_op(24'h800000, 24'ha00000, -1, -1, 5);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort c%0d done pulses", i + 1), 64'(ndone[i]), 64'd0);
      chk($sformatf("abort c%0d busy cycles", i + 1), 64'(nbusy[i]), 64'd6);
      chk($sformatf("abort c%0d q held", i + 1), 64'(Q[i]), 64'h1555555);
      chk($sformatf("abort c%0d sticky held", i + 1), 64'(sticky[i]), 64'd1);
    end
    run_op(24'hc00000, 24'h800000, -1, -1, -1);
    check_op("after_abort", 26'h3000000, 1'b0);

    // Abort together with start in IDLE stays idle.
    X = 24'h800000; D = 24'h800000; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("abort+start c%0d busy", i + 1), 64'(busy[i]), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("abort+start c%0d busy later", i + 1), 64'(busy[i]), 64'd0);

    // Asynchronous reset in the middle of an iteration.
    X = 24'h800000; D = 24'hc00000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async reset c%0d busy", i + 1), 64'(busy[i]), 64'd0);
      chk($sformatf("async reset c%0d done", i + 1), 64'(done[i]), 64'd0);
      chk($sformatf("async reset c%0d q", i + 1), 64'(Q[i]), 64'd0);
      chk($sformatf("async reset c%0d sticky", i + 1), 64'(sticky[i]), 64'd0);
    end
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("post reset c%0d busy", i + 1), 64'(busy[i]), 64'd0);
    run_op(24'he00000, 24'ha00000, -1, -1, -1);
    check_op("post_reset", 26'h2cccccc, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
